// File: rtl/a2_softswitch_pkg.sv
// a2_softswitch_pkg: soft switch addresses, switch vector bit positions and key FSM states
package a2_softswitch_pkg;
    localparam logic [15:0] SW_STORE80_OFF = 16'hC000, SW_STORE80_ON = 16'hC001;
    localparam logic [15:0] SW_RAMRD_OFF   = 16'hC002, SW_RAMRD_ON   = 16'hC003;
    localparam logic [15:0] SW_RAMWRT_OFF  = 16'hC004, SW_RAMWRT_ON  = 16'hC005;
    localparam logic [15:0] SW_CXROM_OFF   = 16'hC006, SW_CXROM_ON   = 16'hC007;
    localparam logic [15:0] SW_ALTZP_OFF   = 16'hC008, SW_ALTZP_ON   = 16'hC009;
    localparam logic [15:0] SW_C3ROM_OFF   = 16'hC00A, SW_C3ROM_ON   = 16'hC00B;
    localparam logic [15:0] SW_COL80_OFF   = 16'hC00C, SW_COL80_ON   = 16'hC00D;
    localparam logic [15:0] SW_ALTCHAR_OFF = 16'hC00E, SW_ALTCHAR_ON = 16'hC00F;
    localparam logic [15:0] SW_TEXT_OFF    = 16'hC050, SW_TEXT_ON    = 16'hC051;
    localparam logic [15:0] SW_MIXED_OFF   = 16'hC052, SW_MIXED_ON   = 16'hC053;
    localparam logic [15:0] SW_PAGE2_OFF   = 16'hC054, SW_PAGE2_ON   = 16'hC055;
    localparam logic [15:0] SW_HIRES_OFF   = 16'hC056, SW_HIRES_ON   = 16'hC057;
    localparam logic [15:0] SW_AN0_OFF     = 16'hC058, SW_AN0_ON     = 16'hC059;
    localparam logic [15:0] SW_AN1_OFF     = 16'hC05A, SW_AN1_ON     = 16'hC05B;
    localparam logic [15:0] SW_AN2_OFF     = 16'hC05C, SW_AN2_ON     = 16'hC05D;
    localparam logic [15:0] SW_AN3_OFF     = 16'hC05E, SW_AN3_ON     = 16'hC05F;
    localparam logic [15:0] GS_TEXTCOL  = 16'hC022, GS_BORDER = 16'hC034;
    localparam logic [15:0] GS_MONO     = 16'hC021, GS_NEWVIDEO = 16'hC029;
    localparam logic [15:0] KBD         = 16'hC000, KBDSTRB   = 16'hC010;
    // Bit positions follow address order, so addr[3:1] indexes the switch directly
    localparam int IIE_STORE80 = 0, IIE_RAMRD = 1, IIE_RAMWRT = 2, IIE_CXROM = 3;
    localparam int IIE_ALTZP = 4, IIE_C3ROM = 5, IIE_COL80 = 6, IIE_ALTCHAR = 7;
    localparam int VID_TEXT = 0, VID_MIXED = 1, VID_PAGE2 = 2, VID_HIRES = 3;
    localparam int VID_AN0 = 4, VID_AN1 = 5, VID_AN2 = 6, VID_AN3 = 7;
    localparam int AUX_STORE80 = 0, AUX_RAMRD = 1, AUX_RAMWRT = 2, AUX_ALTZP = 3;
    localparam int AUX_PAGE2 = 4, AUX_HIRES = 5;
    typedef enum logic {K_EMPTY, K_FULL} key_state_t;
endpackage

// File: rtl/a2mem_if.sv
// a2mem_if: shadowed soft switch, keyboard and aux-targeting state for video scan-out and slots
interface a2mem_if;
    logic store80, ramrd, ramwrt, intcxrom, altzp, slotc3rom, col80, altchar;
    logic text_mode, mixed_mode, page2, hires_mode, an0, an1, an2, an3;
    logic [3:0] text_color, background_color, border_color;
    logic monochrome_mode, shrg_mode, monochrome_dhires_mode;
    logic [7:0] keycode;
    logic keypress_strobe, aux_mem;
    modport master (
        output store80, ramrd, ramwrt, intcxrom, altzp, slotc3rom, col80, altchar,
        output text_mode, mixed_mode, page2, hires_mode, an0, an1, an2, an3,
        output text_color, background_color, border_color,
        output monochrome_mode, shrg_mode, monochrome_dhires_mode,
        output keycode, keypress_strobe, aux_mem
    );
    modport slave (
        input store80, ramrd, ramwrt, intcxrom, altzp, slotc3rom, col80, altchar,
        input text_mode, mixed_mode, page2, hires_mode, an0, an1, an2, an3,
        input text_color, background_color, border_color,
        input monochrome_mode, shrg_mode, monochrome_dhires_mode,
        input keycode, keypress_strobe, aux_mem
    );
endinterface

// File: rtl/a2_softswitch_tracker_aux_decode.sv
// a2_aux_decode: decides whether a bus cycle targets aux RAM from pre-update switch state
module a2_aux_decode
    import a2_softswitch_pkg::*;
(
    input  logic [15:0] addr,
    input  logic        rw_n,
    input  logic [5:0]  sw,
    output logic        aux_hit
);
    logic io, zp, disp;
    always_comb begin
        io      = addr[15:12] == 4'hC;
        zp      = addr < 16'h0200 || addr >= 16'hD000;
        disp    = sw[AUX_STORE80] && (addr[15:10] == 6'b000001 || (sw[AUX_HIRES] && addr[15:13] == 3'b001));
        aux_hit = io ? 1'b0 : zp ? sw[AUX_ALTZP] : disp ? sw[AUX_PAGE2] : rw_n ? sw[AUX_RAMRD] : sw[AUX_RAMWRT];
    end
endmodule

// File: rtl/a2_softswitch_tracker.sv
// a2_softswitch_tracker: passive shadow of II/IIe soft switches, keyboard latch and aux targeting;
// IIgs colour/mode registers are decoded only when A2_SOFTSWITCH_IIGS_EN is defined.
module a2_softswitch_tracker
    import a2_softswitch_pkg::*;
#(
    parameter int         IIE_SWITCHES     = 1,
    parameter logic [3:0] TEXT_COLOR_RST   = 4'hF,
    parameter logic [3:0] BG_COLOR_RST     = 4'h6,
    parameter logic [3:0] BORDER_COLOR_RST = 4'h6
) (
    input  logic        clk_logic,
    input  logic        system_reset,
    input  logic        data_valid,
    input  logic [15:0] addr,
    input  logic [7:0]  data,
    input  logic        rw_n,
    a2mem_if.master     a2mem
);
    logic [7:0] iie_q, iie_d, vid_q, vid_d, keycode_q, keycode_d;
    key_state_t key_q, key_d;
    logic strobe_q, strobe_d, aux_q, aux_d, aux_hit;
    logic iie_hit, vid_hit, kbd_hit, strb_hit;

    a2_aux_decode u_aux (
        .addr    (addr),
        .rw_n    (rw_n),
        .sw      ({vid_q[VID_HIRES], vid_q[VID_PAGE2], iie_q[IIE_ALTZP],
                   iie_q[IIE_RAMWRT], iie_q[IIE_RAMRD], iie_q[IIE_STORE80]}),
        .aux_hit (aux_hit)
    );

    always_comb begin
        iie_hit  = data_valid && !rw_n && IIE_SWITCHES != 0 && addr[15:4] == SW_STORE80_OFF[15:4];
        vid_hit  = data_valid && addr[15:4] == SW_TEXT_OFF[15:4];
        kbd_hit  = data_valid && rw_n && addr[15:4] == KBD[15:4] && data[7];
        strb_hit = data_valid && addr[15:4] == KBDSTRB[15:4];
        iie_d = iie_q;
        vid_d = vid_q;
        if (iie_hit) iie_d[addr[3:1]] = addr[0];
        if (vid_hit) vid_d[addr[3:1]] = addr[0];
        aux_d = data_valid ? aux_hit : aux_q;
    end

    // Strobe is a single-cycle pulse; only the empty->full transition raises it
    always_comb begin
        key_d     = key_q;
        keycode_d = keycode_q;
        strobe_d  = 1'b0;
        if (key_q == K_EMPTY && kbd_hit) begin
            key_d     = K_FULL;
            keycode_d = data;
            strobe_d  = 1'b1;
        end
        if (key_q == K_FULL && strb_hit) key_d = K_EMPTY;
    end

    always_ff @(posedge clk_logic) begin
        if (system_reset) begin
            iie_q     <= '0;
            vid_q     <= 8'h01;
            key_q     <= K_EMPTY;
            keycode_q <= '0;
            strobe_q  <= 1'b0;
            aux_q     <= 1'b0;
        end else begin
            iie_q     <= iie_d;
            vid_q     <= vid_d;
            key_q     <= key_d;
            keycode_q <= keycode_d;
            strobe_q  <= strobe_d;
            aux_q     <= aux_d;
        end
    end

`ifdef A2_SOFTSWITCH_IIGS_EN
    logic [3:0] text_col_q, text_col_d, bg_col_q, bg_col_d, border_q, border_d;
    logic mono_q, mono_d, shrg_q, shrg_d, mdhr_q, mdhr_d;
    logic gs_wr;
    always_comb begin
        gs_wr      = data_valid && !rw_n;
        text_col_d = gs_wr && addr == GS_TEXTCOL ? data[7:4] : text_col_q;
        bg_col_d   = gs_wr && addr == GS_TEXTCOL ? data[3:0] : bg_col_q;
        border_d   = gs_wr && addr == GS_BORDER ? data[3:0] : border_q;
        mono_d     = gs_wr && addr == GS_MONO ? data[7] : mono_q;
        shrg_d     = gs_wr && addr == GS_NEWVIDEO ? data[7] : shrg_q;
        mdhr_d     = gs_wr && addr == GS_NEWVIDEO ? data[5] : mdhr_q;
    end
    always_ff @(posedge clk_logic) begin
        if (system_reset) begin
            text_col_q <= TEXT_COLOR_RST;
            bg_col_q   <= BG_COLOR_RST;
            border_q   <= BORDER_COLOR_RST;
            mono_q     <= 1'b0;
            shrg_q     <= 1'b0;
            mdhr_q     <= 1'b0;
        end else begin
            text_col_q <= text_col_d;
            bg_col_q   <= bg_col_d;
            border_q   <= border_d;
            mono_q     <= mono_d;
            shrg_q     <= shrg_d;
            mdhr_q     <= mdhr_d;
        end
    end
    assign a2mem.text_color             = text_col_q;
    assign a2mem.background_color       = bg_col_q;
    assign a2mem.border_color           = border_q;
    assign a2mem.monochrome_mode        = mono_q;
    assign a2mem.shrg_mode              = shrg_q;
    assign a2mem.monochrome_dhires_mode = mdhr_q;
`else
    assign a2mem.text_color             = TEXT_COLOR_RST;
    assign a2mem.background_color       = BG_COLOR_RST;
    assign a2mem.border_color           = BORDER_COLOR_RST;
    assign a2mem.monochrome_mode        = 1'b0;
    assign a2mem.shrg_mode              = 1'b0;
    assign a2mem.monochrome_dhires_mode = 1'b0;
`endif

    assign a2mem.store80         = iie_q[IIE_STORE80];
    assign a2mem.ramrd           = iie_q[IIE_RAMRD];
    assign a2mem.ramwrt          = iie_q[IIE_RAMWRT];
    assign a2mem.intcxrom        = iie_q[IIE_CXROM];
    assign a2mem.altzp           = iie_q[IIE_ALTZP];
    assign a2mem.slotc3rom       = iie_q[IIE_C3ROM];
    assign a2mem.col80           = iie_q[IIE_COL80];
    assign a2mem.altchar         = iie_q[IIE_ALTCHAR];
    assign a2mem.text_mode       = vid_q[VID_TEXT];
    assign a2mem.mixed_mode      = vid_q[VID_MIXED];
    assign a2mem.page2           = vid_q[VID_PAGE2];
    assign a2mem.hires_mode      = vid_q[VID_HIRES];
    assign a2mem.an0             = vid_q[VID_AN0];
    assign a2mem.an1             = vid_q[VID_AN1];
    assign a2mem.an2             = vid_q[VID_AN2];
    assign a2mem.an3             = vid_q[VID_AN3];
    assign a2mem.keycode         = keycode_q;
    assign a2mem.keypress_strobe = strobe_q;
    assign a2mem.aux_mem         = aux_q;
endmodule

// File: tb/tb_a2_softswitch_tracker.sv
// tb_a2_softswitch_tracker: directed checks of the tracker in IIe mode and in II+ mode
module tb_a2_softswitch_tracker;
    logic clk = 1'b0, system_reset = 1'b0, data_valid = 1'b0, rw_n = 1'b1;
    logic [15:0] addr = '0;
    logic [7:0] data = '0;
    int checks = 0, errors = 0;

    a2mem_if bus1 ();
    a2mem_if bus2 ();

    a2_softswitch_tracker dut (
        .clk_logic (clk), .system_reset (system_reset), .data_valid (data_valid),
        .addr (addr), .data (data), .rw_n (rw_n), .a2mem (bus1)
    );
    a2_softswitch_tracker #(.IIE_SWITCHES (0)) dut_iiplus (
        .clk_logic (clk), .system_reset (system_reset), .data_valid (data_valid),
        .addr (addr), .data (data), .rw_n (rw_n), .a2mem (bus2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic [15:0] a, input logic [7:0] d, input logic r);
        @(negedge clk);
        addr = a; data = d; rw_n = r; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        system_reset = 1'b1; data_valid = 1'b1; addr = 16'hC051; rw_n = 1'b0;
        @(negedge clk);
        system_reset = 1'b1; addr = 16'hC001;
        @(negedge clk);
        system_reset = 1'b0; data_valid = 1'b0;
        check("rst_text", bus1.text_mode, 1);
        check("rst_store80", bus1.store80, 0);
        check("rst_textcol", bus1.text_color, 8'h0F);
        check("rst_bgcol", bus1.background_color, 8'h06);
        check("rst_border", bus1.border_color, 8'h06);
        check("rst_keycode", bus1.keycode, 8'h00);
        check("rst_strobe", bus1.keypress_strobe, 0);
        check("rst_aux", bus1.aux_mem, 0);
        check("rst_page2", bus1.page2, 0);
        check("rst_shrg", bus1.shrg_mode, 0);
        idle();
        check("idle_store80", bus1.store80, 0);

        cyc(16'hC001, 8'h00, 0); check("store80_set", bus1.store80, 1);
        cyc(16'hC055, 8'h00, 1); check("page2_set_rd", bus1.page2, 1);
        cyc(16'h0400, 8'h00, 0); check("aux_txt_page2", bus1.aux_mem, 1);
        idle();                  check("aux_hold", bus1.aux_mem, 1);
        cyc(16'hC054, 8'h00, 1); check("page2_clr", bus1.page2, 0);
                                 check("aux_io", bus1.aux_mem, 0);
        cyc(16'h0400, 8'h00, 0); check("aux_txt_main", bus1.aux_mem, 0);

        cyc(16'hC000, 8'hC1, 1); check("key1_code", bus1.keycode, 8'hC1);
                                 check("key1_strobe", bus1.keypress_strobe, 1);
                                 check("key1_store80", bus1.store80, 1);
        idle();                  check("key1_strobe_end", bus1.keypress_strobe, 0);
        cyc(16'hC000, 8'hC2, 1); check("key_full_strobe", bus1.keypress_strobe, 0);
                                 check("key_full_code", bus1.keycode, 8'hC1);
        cyc(16'hC010, 8'h00, 0); check("kbdstrb_nostrobe", bus1.keypress_strobe, 0);
        cyc(16'hC000, 8'hC2, 1); check("key2_strobe", bus1.keypress_strobe, 1);
                                 check("key2_code", bus1.keycode, 8'hC2);

        cyc(16'hC003, 8'h00, 1); check("ramrd_read_ign", bus1.ramrd, 0);
        cyc(16'hC003, 8'h00, 0); check("ramrd_set", bus1.ramrd, 1);
        cyc(16'h5000, 8'h00, 1); check("aux_ramrd", bus1.aux_mem, 1);
        cyc(16'h5000, 8'h00, 0); check("aux_ramwrt", bus1.aux_mem, 0);

        cyc(16'hC057, 8'h00, 1); check("hires_set", bus1.hires_mode, 1);
        cyc(16'hC055, 8'h00, 0); check("page2_set_wr", bus1.page2, 1);
        cyc(16'h2000, 8'h00, 0); check("aux_hires_p2", bus1.aux_mem, 1);
        cyc(16'hC054, 8'h00, 0);
        cyc(16'h2000, 8'h00, 1); check("aux_hires_p1", bus1.aux_mem, 0);

        cyc(16'hC009, 8'h00, 0); check("altzp_set", bus1.altzp, 1);
        cyc(16'h0100, 8'h00, 0); check("aux_zp", bus1.aux_mem, 1);
        cyc(16'hC100, 8'h00, 1); check("aux_cxxx", bus1.aux_mem, 0);
        cyc(16'hD000, 8'h00, 1); check("aux_lc", bus1.aux_mem, 1);
        cyc(16'h0200, 8'h00, 0); check("aux_0200", bus1.aux_mem, 0);

        cyc(16'hC050, 8'h00, 0); check("text_clr", bus1.text_mode, 0);
        cyc(16'hC151, 8'h00, 1); check("mirror_ign", bus1.text_mode, 0);
        cyc(16'hC051, 8'h00, 1); check("text_set", bus1.text_mode, 1);
        cyc(16'hC05B, 8'h00, 1); check("an1_set", bus1.an1, 1);
                                 check("an0_clear", bus1.an0, 0);

        cyc(16'hC022, 8'h2E, 0);
        cyc(16'hC034, 8'h05, 0);
        cyc(16'hC029, 8'hA0, 0);
`ifdef A2_SOFTSWITCH_IIGS_EN
        check("gs_text", bus1.text_color, 8'h02);
        check("gs_bg", bus1.background_color, 8'h0E);
        check("gs_border", bus1.border_color, 8'h05);
        check("gs_shrg", bus1.shrg_mode, 1);
        check("gs_mdhr", bus1.monochrome_dhires_mode, 1);
`else
        check("gs_text", bus1.text_color, 8'h0F);
        check("gs_bg", bus1.background_color, 8'h06);
        check("gs_border", bus1.border_color, 8'h06);
        check("gs_shrg", bus1.shrg_mode, 0);
        check("gs_mdhr", bus1.monochrome_dhires_mode, 0);
`endif

        cyc(16'hC005, 8'h00, 0); check("iie_ramwrt", bus1.ramwrt, 1);
        check("iiplus_ramwrt", bus2.ramwrt, 0);
        check("iiplus_altzp", bus2.altzp, 0);
        check("iiplus_ramrd", bus2.ramrd, 0);
        check("iiplus_store80", bus2.store80, 0);
        check("iiplus_hires", bus2.hires_mode, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
